frame_buffer: RTL and testbench

- Double-buffered scene memory directly upstream of the VGA scan-out controller.
- Supplies the 6-bit pixel colour for the scene coordinate the scan-out requests, one cycle later.
- Accepts pixel writes from game/render logic into the back bank through a valid/ready handshake.
- Swaps banks at the start of vertical porch, then clears the new back bank with a hardware clear engine.

---
 rtl/frame_buffer.sv | 147 ++++++++++++++
 tb/tb_frame_buffer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/frame_buffer.sv
// Double-buffered scene memory feeding VGA scan-out: registered front-bank read,
// handshaked back-bank writes, swap on frame_start, and a hardware clear engine.
module frame_buffer #(
  parameter int                 SCENE_WIDTH  = 400,
  parameter int                 SCENE_HEIGHT = 300,
  parameter int                 COLOR_W      = 6,
  parameter logic [COLOR_W-1:0] CLEAR_COLOR  = '0
) (
  input  logic               pixel_clk,
  input  logic               rst_n,
  input  logic [8:0]         rd_x,
  input  logic [8:0]         rd_y,
  input  logic               rd_en,
  output logic [COLOR_W-1:0] rgb_color,
  input  logic               frame_start,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [8:0]         wr_x,
  input  logic [8:0]         wr_y,
  input  logic [COLOR_W-1:0] wr_color,
  input  logic               frame_done,
  output logic               swap_pending,
  output logic               clear_busy,
  output logic               front_sel
);

  localparam int                N       = SCENE_WIDTH * SCENE_HEIGHT;
  localparam int                ADDR_W  = (N > 1) ? $clog2(N) : 1;
  localparam logic [ADDR_W-1:0] L_LAST  = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] L_WIDTH = ADDR_W'(SCENE_WIDTH);
  localparam logic [9:0]        L_W10   = 10'(SCENE_WIDTH);
  localparam logic [9:0]        L_H10   = 10'(SCENE_HEIGHT);

  typedef enum logic [1:0] {
    S_CLEAR_ALL,
    S_DRAW,
    S_WAIT_SWAP,
    S_CLEAR_BACK
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_cnt;
  logic                r_front_sel;
  logic                r_rd_valid;
  logic                r_rd_clear;
  logic                r_rd_sel;

  logic                w_rd_in;
  logic                w_wr_in;
  logic [ADDR_W-1:0]   w_rd_addr;
  logic [ADDR_W-1:0]   w_wr_addr;
  logic                w_swap;
  logic                w_clearing;
  logic [1:0]          w_we;
  logic [ADDR_W-1:0]   w_waddr;
  logic [COLOR_W-1:0]  w_wdata;

  assign w_rd_in   = ({1'b0, rd_x} < L_W10) && ({1'b0, rd_y} < L_H10);
  assign w_wr_in   = ({1'b0, wr_x} < L_W10) && ({1'b0, wr_y} < L_H10);
  assign w_rd_addr = w_rd_in ? (ADDR_W'(rd_y) * L_WIDTH + ADDR_W'(rd_x)) : '0;
  assign w_wr_addr = w_wr_in ? (ADDR_W'(wr_y) * L_WIDTH + ADDR_W'(wr_x)) : '0;
  assign w_swap    = (r_state == S_WAIT_SWAP) && frame_start;

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_CLEAR_ALL;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_CLEAR_ALL:  if (r_cnt == L_LAST) w_state_next = S_DRAW;
      S_DRAW:       if (frame_done)      w_state_next = S_WAIT_SWAP;
      S_WAIT_SWAP:  if (frame_start)     w_state_next = S_CLEAR_BACK;
      S_CLEAR_BACK: if (r_cnt == L_LAST) w_state_next = S_DRAW;
      default:                           w_state_next = S_CLEAR_ALL;
    endcase
  end

  // Bank write port: w_we[gi] selects which bank takes the word this cycle.
  always_comb begin
    wr_ready     = 1'b0;
    swap_pending = 1'b0;
    w_clearing   = 1'b0;
    w_we         = 2'b00;
    w_waddr      = r_cnt;
    w_wdata      = CLEAR_COLOR;
    case (r_state)
      S_CLEAR_ALL: begin
        w_clearing = 1'b1;
        w_we       = 2'b11;
      end
      S_DRAW: begin
        wr_ready = 1'b1;
        if (wr_valid && w_wr_in) begin
          w_we    = r_front_sel ? 2'b01 : 2'b10;
          w_waddr = w_wr_addr;
          w_wdata = wr_color;
        end
      end
      S_WAIT_SWAP: swap_pending = 1'b1;
      S_CLEAR_BACK: begin
        w_clearing = 1'b1;
        w_we       = r_front_sel ? 2'b01 : 2'b10;
      end
      default: ;
    endcase
  end

  assign clear_busy = w_clearing;

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_front_sel <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_clear  <= 1'b0;
      r_rd_sel    <= 1'b0;
    end else begin
      if (w_clearing) r_cnt <= (r_cnt == L_LAST) ? '0 : r_cnt + ADDR_W'(1);
      else            r_cnt <= '0;
      if (w_swap) r_front_sel <= ~r_front_sel;
      r_rd_valid <= rd_en && w_rd_in && (r_state != S_CLEAR_ALL);
      r_rd_clear <= (r_state == S_CLEAR_ALL);
      // A read in the swap cycle must already see the new front bank.
      r_rd_sel   <= r_front_sel ^ w_swap;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      logic [COLOR_W-1:0] r_mem [N];
      logic [COLOR_W-1:0] r_rd_data;
      always_ff @(posedge pixel_clk) begin
        if (w_we[gi]) r_mem[w_waddr] <= w_wdata;
        r_rd_data <= r_mem[w_rd_addr];
      end
    end
  endgenerate

  assign front_sel = r_front_sel;
  assign rgb_color = r_rd_clear ? CLEAR_COLOR :
                     r_rd_valid ? (r_rd_sel ? g_bank[1].r_rd_data : g_bank[0].r_rd_data) :
                     '0;

endmodule

// File: tb/tb_frame_buffer.sv
// Directed table-driven bench for frame_buffer on an 8x4 scene.
module tb_frame_buffer;

  logic       pixel_clk = 1'b0;
  logic       rst_n;
  logic [8:0] rd_x, rd_y, wr_x, wr_y;
  logic       rd_en, frame_start, wr_valid, frame_done;
  logic [5:0] wr_color, rgb_color;
  logic       wr_ready, swap_pending, clear_busy, front_sel;

  int checks = 0;
  int passes = 0;

  frame_buffer #(.SCENE_WIDTH(8), .SCENE_HEIGHT(4), .COLOR_W(6), .CLEAR_COLOR(6'h00)) dut (
    .pixel_clk(pixel_clk), .rst_n(rst_n),
    .rd_x(rd_x), .rd_y(rd_y), .rd_en(rd_en), .rgb_color(rgb_color),
    .frame_start(frame_start), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color), .frame_done(frame_done),
    .swap_pending(swap_pending), .clear_busy(clear_busy), .front_sel(front_sel)
  );

  always #5 pixel_clk = ~pixel_clk;

  typedef struct {
    logic       rd_en;
    logic [8:0] rd_x, rd_y;
    logic       wr_valid;
    logic [8:0] wr_x, wr_y;
    logic [5:0] wr_color;
    logic       fdone, fstart;
    logic [5:0] e_rgb;
    logic       e_ready, e_sp, e_cb, e_fs;
  } vec_t;

  vec_t vt[20];

  function automatic vec_t mk(input logic re, input int rx, input int ry,
                              input logic wv, input int wx, input int wy, input logic [5:0] wc,
                              input logic fd, input logic fs_in,
                              input logic [5:0] e_rgb, input logic e_ready, input logic e_sp,
                              input logic e_cb, input logic e_fs);
    vec_t v;
    v.rd_en = re;   v.rd_x = 9'(rx); v.rd_y = 9'(ry);
    v.wr_valid = wv; v.wr_x = 9'(wx); v.wr_y = 9'(wy); v.wr_color = wc;
    v.fdone = fd;   v.fstart = fs_in;
    v.e_rgb = e_rgb; v.e_ready = e_ready; v.e_sp = e_sp; v.e_cb = e_cb; v.e_fs = e_fs;
    return v;
  endfunction

  task automatic drive_idle();
    rd_en = 0; rd_x = 0; rd_y = 0; wr_valid = 0; wr_x = 0; wr_y = 0;
    wr_color = 0; frame_done = 0; frame_start = 0;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) begin
      passes++;
      $display("check %-14s ok   got=%0h", name, act);
    end else begin
      $display("FAIL %-14s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic apply(input int i);
    logic [9:0] act, exp;
    @(negedge pixel_clk);
    rd_en = vt[i].rd_en; rd_x = vt[i].rd_x; rd_y = vt[i].rd_y;
    wr_valid = vt[i].wr_valid; wr_x = vt[i].wr_x; wr_y = vt[i].wr_y; wr_color = vt[i].wr_color;
    frame_done = vt[i].fdone; frame_start = vt[i].fstart;
    @(posedge pixel_clk);
    #1;
    act = {rgb_color, wr_ready, swap_pending, clear_busy, front_sel};
    exp = {vt[i].e_rgb, vt[i].e_ready, vt[i].e_sp, vt[i].e_cb, vt[i].e_fs};
    checks++;
    if (act == exp) begin
      passes++;
      $display("vec%0d ok   rgb=%h rdy=%b sp=%b cb=%b fs=%b", i, rgb_color, wr_ready,
               swap_pending, clear_busy, front_sel);
    end else begin
      $display("FAIL vec%0d got rgb=%h rdy=%b sp=%b cb=%b fs=%b expected rgb=%h rdy=%b sp=%b cb=%b fs=%b",
               i, rgb_color, wr_ready, swap_pending, clear_busy, front_sel,
               vt[i].e_rgb, vt[i].e_ready, vt[i].e_sp, vt[i].e_cb, vt[i].e_fs);
    end
  endtask

  task automatic run(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) apply(i);
  endtask

  // Counts edges until clear_busy falls, bounded so a stuck engine still ends.
  task automatic wait_clear(input string name, input int exp);
    int n = 0;
    drive_idle();
    while (clear_busy === 1'b1 && n < 100) begin
      @(posedge pixel_clk);
      #1;
      n++;
    end
    check(name, n, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    //             re rx ry wv wx wy col   fd fs  rgb   rdy sp cb fs
    vt[0]  = mk(1, 3, 2, 0, 0, 0, 6'h00, 0, 0, 6'h00, 1, 0, 0, 0);
    vt[1]  = mk(0, 0, 0, 1, 5, 1, 6'h2A, 0, 0, 6'h00, 1, 0, 0, 0);
    vt[2]  = mk(1, 5, 1, 1, 8, 0, 6'h3F, 0, 0, 6'h00, 1, 0, 0, 0);
    vt[3]  = mk(0, 0, 0, 1, 2, 3, 6'h11, 1, 0, 6'h00, 0, 1, 0, 0);
    vt[4]  = mk(1, 2, 3, 1, 5, 1, 6'h3F, 0, 0, 6'h00, 0, 1, 0, 0);
    vt[5]  = mk(1, 5, 1, 0, 0, 0, 6'h00, 0, 1, 6'h2A, 0, 0, 1, 1);
    vt[6]  = mk(1, 2, 3, 0, 0, 0, 6'h00, 1, 0, 6'h11, 0, 0, 1, 1);
    vt[7]  = mk(1, 0, 1, 0, 0, 0, 6'h00, 0, 1, 6'h00, 0, 0, 1, 1);
    vt[8]  = mk(1, 13, 0, 0, 0, 0, 6'h00, 0, 0, 6'h00, 0, 0, 1, 1);
    vt[9]  = mk(0, 5, 1, 0, 0, 0, 6'h00, 0, 0, 6'h00, 0, 0, 1, 1);
    vt[10] = mk(1, 5, 1, 1, 5, 1, 6'h15, 0, 0, 6'h2A, 1, 0, 0, 1);
    vt[11] = mk(1, 5, 1, 0, 0, 0, 6'h00, 0, 0, 6'h2A, 1, 0, 0, 1);
    vt[12] = mk(1, 5, 1, 0, 0, 0, 6'h00, 1, 0, 6'h2A, 0, 1, 0, 1);
    vt[13] = mk(1, 5, 1, 0, 0, 0, 6'h00, 0, 1, 6'h15, 0, 0, 1, 0);
    vt[14] = mk(1, 0, 0, 0, 0, 0, 6'h00, 0, 0, 6'h00, 0, 0, 1, 0);
    vt[15] = mk(1, 2, 3, 0, 0, 0, 6'h00, 0, 0, 6'h00, 0, 0, 1, 0);
    vt[16] = mk(1, 5, 1, 0, 0, 0, 6'h00, 1, 1, 6'h15, 0, 1, 0, 0);
    vt[17] = mk(1, 5, 1, 0, 0, 0, 6'h00, 0, 0, 6'h15, 0, 1, 0, 0);
    vt[18] = mk(1, 5, 1, 0, 0, 0, 6'h00, 0, 1, 6'h00, 0, 0, 1, 1);
    vt[19] = mk(1, 5, 1, 0, 0, 0, 6'h00, 0, 0, 6'h00, 1, 0, 0, 0);

    drive_idle();
    rst_n = 1'b0;
    repeat (3) @(posedge pixel_clk);
    #1;
    check("rst_outputs", int'({rgb_color, wr_ready, swap_pending, clear_busy, front_sel}),
          int'({6'h00, 1'b0, 1'b0, 1'b1, 1'b0}));
    @(negedge pixel_clk);
    rst_n = 1'b1;
    wait_clear("clear_all_len", 32);
    check("ready_after_ca", int'(wr_ready), 1);

    run(0, 5);
    // Four vectors already consumed edges of the 32-cycle back clear.
    run(6, 9);
    wait_clear("clear_back_len", 28);
    run(10, 15);
    wait_clear("clear_back2_len", 30);
    run(16, 18);

    // Reset while the back clear is at count 10.
    drive_idle();
    repeat (10) @(posedge pixel_clk);
    #1;
    check("pre_rst_state", int'({clear_busy, front_sel}), int'(2'b11));
    #1;
    rst_n = 1'b0;
    #1;
    check("midclr_rst", int'({rgb_color, wr_ready, swap_pending, clear_busy, front_sel}),
          int'({6'h00, 1'b0, 1'b0, 1'b1, 1'b0}));
    @(negedge pixel_clk);
    rst_n = 1'b1;
    wait_clear("reclear_len", 32);
    check("ready_after_rc", int'(wr_ready), 1);
    run(19, 19);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
